// File: rtl/alu_8bit.sv
// ---------------------------------------------------------------------------
// alu_8bit
//   8-bit add/subtract unit for the simple CPU datapath.
//   A single 9-bit adder computes a + b, or a - b as a + ~b + 1.
//   The zero/carry flags and the gated bus value are purely combinational.
//   A small clocked flag register captures the flags for conditional jumps.
//
// Ports
//   clk         system clock; the flag register updates on the rising edge
//   rst         asynchronous active-high reset; clears zf_q/cf_q
//   a, b        8-bit operands from the A and B registers
//   sub         0 = add, 1 = subtract (a - b)
//   out         combinational 8-bit result
//   flag_zero   1 when out == 8'h00
//   flag_carry  adder carry-out (for subtract: 1 = no borrow, a >= b)
//   flags_load  capture flag_zero/flag_carry on the next rising clk edge
//   out_en      bus drive enable
//   bus_out     out when out_en = 1, else 8'h00 (no tri-state on chip)
//   zf_q, cf_q  registered zero / carry flags
// ---------------------------------------------------------------------------
module alu_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    output logic [7:0] out,
    output logic       flag_zero,
    output logic       flag_carry,
    input  logic       flags_load,
    input  logic       out_en,
    output logic [7:0] bus_out,
    output logic       zf_q,
    output logic       cf_q
);

    // Operand B is inverted for subtraction. The carry-in of 1 then completes
    // the two's-complement negate, so one adder covers both operations.
    logic [7:0] b_eff;
    logic [8:0] sum;

    always_comb begin
        b_eff = b ^ {8{sub}};
        sum   = {1'b0, a} + {1'b0, b_eff} + {8'h00, sub};
    end

    assign out        = sum[7:0];
    assign flag_carry = sum[8];
    assign flag_zero  = (sum[7:0] == 8'h00);

    // AND-gated bus driver. An idle ALU contributes zeros to the OR-combined
    // internal bus.
    assign bus_out = out_en ? sum[7:0] : 8'h00;

    // The flag register holds its value unless the sequencer requests a load.
    // Reset takes priority over a coincident load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zf_q <= 1'b0;
            cf_q <= 1'b0;
        end else if (flags_load) begin
            zf_q <= flag_zero;
            cf_q <= flag_carry;
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
module tb_alu_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic       sub;
    logic [7:0] out;
    logic       flag_zero, flag_carry;
    logic       flags_load;
    logic       out_en;
    logic [7:0] bus_out;
    logic       zf_q, cf_q;

    int checks   = 0;
    int failures = 0;

    alu_8bit dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .sub(sub), .out(out),
        .flag_zero(flag_zero), .flag_carry(flag_carry),
        .flags_load(flags_load), .out_en(out_en), .bus_out(bus_out),
        .zf_q(zf_q), .cf_q(cf_q)
    );

    always #5 clk = ~clk;

    // Scoreboard entry: expected combinational outputs for one stimulus.
    typedef struct {
        logic [7:0] o;
        logic       z;
        logic       c;
        logic [7:0] bus;
    } exp_t;

    exp_t sb[$];

    // Reference model, written from the arithmetic definition rather than
    // from the adder structure.
    function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb,
                                   input logic ms, input logic men);
        exp_t e;
        int   r;
        if (ms) begin
            r   = int'(ma) - int'(mb);
            e.c = (ma >= mb);
        end else begin
            r   = int'(ma) + int'(mb);
            e.c = (r > 255);
        end
        e.o   = r[7:0];
        e.z   = (e.o == 8'h00);
        e.bus = men ? e.o : 8'h00;
        return e;
    endfunction

    // Drive one stimulus and push its expected outputs.
    task automatic drive(input logic [7:0] da, input logic [7:0] db,
                         input logic ds, input logic den);
        a = da; b = db; sub = ds; out_en = den;
        sb.push_back(model(da, db, ds, den));
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; flags_load = 1'b0;
        drive(8'h01, 8'h02, 1'b1, 1'b1);
        #1;
        checks++;
        if ({zf_q, cf_q} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00", {zf_q, cf_q});
        end
        // Combinational outputs keep following their inputs during reset.
        e = sb.pop_front();
        checks++;
        if ({out, flag_zero, flag_carry, bus_out} !== {e.o, e.z, e.c, e.bus}) begin
            failures++;
            $display("FAIL reset_comb got=%h/%b%b/%h exp=%h/%b%b/%h",
                     out, flag_zero, flag_carry, bus_out, e.o, e.z, e.c, e.bus);
        end
        // A load request held across an edge during reset is ignored.
        drive(8'h05, 8'h05, 1'b1, 1'b0);
        void'(sb.pop_front());
        flags_load = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({zf_q, cf_q} !== 2'b00) begin
            failures++;
            $display("FAIL reset_load_edge got=%b exp=00", {zf_q, cf_q});
        end
        @(negedge clk);
        flags_load = 1'b0;
        rst = 1'b0;
        // Releasing reset alone must not update the flags.
        @(posedge clk); #1;
        checks++;
        if ({zf_q, cf_q} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release got=%b exp=00", {zf_q, cf_q});
        end
    endtask

    task automatic test_arith();
        logic [7:0] ta [10] = '{8'h01, 8'h05, 8'hFF, 8'h10, 8'h00, 8'hFF, 8'h80, 8'h00, 8'h7F, 8'hFF};
        logic [7:0] tb_ [10] = '{8'h02, 8'h05, 8'h01, 8'h20, 8'h00, 8'hFF, 8'h80, 8'h01, 8'h80, 8'h00};
        logic       ts [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(ta[i], tb_[i], ts[i], 1'b1);
            #1;
            e = sb.pop_front();
            checks++;
            if ({out, flag_zero, flag_carry, bus_out} !== {e.o, e.z, e.c, e.bus}) begin
                failures++;
                $display("FAIL arith[%0d] a=%h b=%h sub=%b got=%h/z%b/c%b/%h exp=%h/z%b/c%b/%h",
                         i, ta[i], tb_[i], ts[i], out, flag_zero, flag_carry, bus_out,
                         e.o, e.z, e.c, e.bus);
            end
        end
        // Spot-check the listed vectors against hand-derived constants too.
        @(negedge clk);
        drive(8'h01, 8'h02, 1'b1, 1'b1); void'(sb.pop_front()); #1;
        checks++;
        if ({out, flag_zero, flag_carry} !== {8'hFF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL sub_borrow got=%h/z%b/c%b exp=ff/z0/c0", out, flag_zero, flag_carry);
        end
        drive(8'hFF, 8'h01, 1'b0, 1'b1); void'(sb.pop_front()); #1;
        checks++;
        if ({out, flag_zero, flag_carry} !== {8'h00, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL add_wrap got=%h/z%b/c%b exp=00/z1/c1", out, flag_zero, flag_carry);
        end
    endtask

    task automatic test_bus();
        exp_t e;
        @(negedge clk);
        drive(8'h03, 8'h04, 1'b0, 1'b0);
        #1;
        e = sb.pop_front();
        checks++;
        if (bus_out !== e.bus || bus_out !== 8'h00) begin
            failures++;
            $display("FAIL bus_disabled got=%h exp=%h", bus_out, e.bus);
        end
        drive(8'h03, 8'h04, 1'b0, 1'b1);
        #1;
        e = sb.pop_front();
        checks++;
        if (bus_out !== e.bus || bus_out !== 8'h07) begin
            failures++;
            $display("FAIL bus_enabled got=%h exp=%h", bus_out, e.bus);
        end
    endtask

    task automatic test_flag_reg();
        @(negedge clk);
        drive(8'h05, 8'h05, 1'b1, 1'b0); void'(sb.pop_front());
        flags_load = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({zf_q, cf_q} !== 2'b11) begin
            failures++;
            $display("FAIL flag_load_eq got=%b exp=11", {zf_q, cf_q});
        end
        @(negedge clk);
        drive(8'h01, 8'h02, 1'b1, 1'b0); void'(sb.pop_front());
        flags_load = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({zf_q, cf_q} !== 2'b11) begin
            failures++;
            $display("FAIL flag_hold got=%b exp=11", {zf_q, cf_q});
        end
        @(negedge clk);
        flags_load = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({zf_q, cf_q} !== 2'b00) begin
            failures++;
            $display("FAIL flag_load_lt got=%b exp=00", {zf_q, cf_q});
        end
        @(negedge clk);
        flags_load = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(8'h05, 8'h05, 1'b1, 1'b0); void'(sb.pop_front());
        flags_load = 1'b1;
        @(posedge clk); #1;
        flags_load = 1'b0;
        checks++;
        if ({zf_q, cf_q} !== 2'b11) begin
            failures++;
            $display("FAIL async_pre got=%b exp=11", {zf_q, cf_q});
        end
        // Assert reset mid-cycle, well away from any clock edge.
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({zf_q, cf_q} !== 2'b00) begin
            failures++;
            $display("FAIL async_clear got=%b exp=00", {zf_q, cf_q});
        end
        flags_load = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({zf_q, cf_q} !== 2'b00) begin
            failures++;
            $display("FAIL async_hold_load got=%b exp=00", {zf_q, cf_q});
        end
        @(negedge clk);
        rst = 1'b0;
        flags_load = 1'b0;
    endtask

    // Random back-to-back vectors with random loads. The bench keeps its own
    // copy of the registered flags.
    task automatic test_back_to_back();
        exp_t e;
        logic zm = zf_q === 1'b1 ? 1'b1 : 1'b0;
        logic cm = cf_q === 1'b1 ? 1'b1 : 1'b0;
        // zf_q/cf_q are known zero after the preceding reset test.
        zm = 1'b0; cm = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            flags_load = 1'($urandom_range(0, 1));
            #1;
            e = sb.pop_front();
            checks++;
            if ({out, flag_zero, flag_carry, bus_out} !== {e.o, e.z, e.c, e.bus}) begin
                failures++;
                $display("FAIL rand_comb[%0d] a=%h b=%h sub=%b got=%h/z%b/c%b/%h exp=%h/z%b/c%b/%h",
                         i, a, b, sub, out, flag_zero, flag_carry, bus_out, e.o, e.z, e.c, e.bus);
            end
            if (flags_load) begin
                zm = e.z; cm = e.c;
            end
            @(posedge clk); #1;
            checks++;
            if ({zf_q, cf_q} !== {zm, cm}) begin
                failures++;
                $display("FAIL rand_flags[%0d] got=%b exp=%b", i, {zf_q, cf_q}, {zm, cm});
            end
        end
        flags_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; sub = 1'b0; flags_load = 1'b0; out_en = 1'b0;
        test_reset();
        test_arith();
        test_bus();
        test_flag_reg();
        test_async_reset();
        test_back_to_back();
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
